scan_frame_ctrl: RTL and testbench
==================================

Name: scan_frame_ctrl

Overview:
- Frame-level sequencer for the SCAN decoder core.
- Accepts a stream of channel LLRs over a valid/ready handshake and forwards them to the core while holding its channel input low.
- Raises channel for a configurable number of SCAN iterations, captures the core's decoded bits into an output register, and returns the core to load state with a one-cycle flush reset.
- Sits between the upstream demapper/LLR source and the decoder core; presents decoded frames downstream over a second valid/ready handshake.

Parameters:
- N, 1024, code length (LLRs per frame, decoded bits per frame).
- Q, 6, LLR quantization width.
- ITER_CYCLES, 2048, core clocks per SCAN iteration with channel high.
- MAX_ITER, 8, maximum iterations; cfg_iter is clamped to this.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- s_llr_valid  in  1  upstream LLR beat valid.
- s_llr_ready  out  1  controller accepts LLR beat.
- s_llr_data  in  Q  LLR value.
- cfg_iter  in  4  iteration count, sampled on first beat of a frame.
- core_channel  out  1  to core channel input; 0 = load LLRs, 1 = decode.
- core_rst  out  1  to core rst input; flush pulse.
- core_llr  out  Q  to core in_LLR.
- core_bits  in  N  core decoded_bits.
- m_bits_valid  out  1  decoded frame available.
- m_bits_ready  in  1  downstream accepts frame.
- m_bits  out  N  decoded frame register.
- busy  out  1  state != IDLE.
- underrun  out  1  sticky: valid dropped mid-frame.
- frame_cnt  out  16  frames delivered, wraps at 2^16.

Behaviour:
- Reset (async, any state): state=IDLE, core_channel=0, core_rst=1, core_llr=0, m_bits=0, m_bits_valid=0, underrun=0, frame_cnt=0, beat/cycle counters=0.
- States: IDLE, LOAD, DECODE, CAPTURE, FLUSH.
- core_channel=1 only in DECODE. core_rst=1 in FLUSH and during reset, otherwise 0.
- core_llr is registered: data accepted at cycle t appears at cycle t+1.
- s_llr_ready:
  - IDLE: !m_bits_valid || m_bits_ready.
  - LOAD: 1.
  - All other states: 0.
- IDLE:
  - On a handshake (valid && ready), latch iter_eff from cfg_iter; 0 maps to 1, values above MAX_ITER map to MAX_ITER.
  - beat_cnt := 1, go to LOAD.
- LOAD:
  - Every cycle must carry a handshake. Each beat increments beat_cnt.
  - On the beat making beat_cnt == N, go to DECODE; cyc_cnt := 0.
  - If s_llr_valid=0 in any LOAD cycle: set underrun, go to FLUSH, discard the frame (no output, frame_cnt unchanged).
- DECODE:
  - cyc_cnt increments each cycle.
  - When cyc_cnt == ITER_CYCLES*iter_eff - 1, go to CAPTURE.
  - Total decode cycles = ITER_CYCLES*iter_eff exactly.
- CAPTURE (1 cycle, core_channel=0):
  - m_bits := core_bits, m_bits_valid := 1, go to FLUSH.
  - The IDLE ready rule guarantees m_bits is free at this point.
- FLUSH (1 cycle): core_rst=1, go to IDLE.
- Output handshake:
  - m_bits and m_bits_valid hold stable until m_bits_ready.
  - On valid && ready: m_bits_valid := 0, frame_cnt++ (wrap 0xFFFF -> 0).
  - If CAPTURE and the output handshake occur in the same cycle, m_bits_valid stays 1 with the new data and frame_cnt still increments.
- underrun clears only on rst.
- Latency from first beat to m_bits_valid: N + ITER_CYCLES*iter_eff + 1 cycles.
- Minimum frame-to-frame spacing: N + ITER_CYCLES*iter_eff + 2 cycles.

Test Plan:
- N=8, ITER_CYCLES=10, cfg_iter=1, 8 contiguous beats 1..8 -> core_llr shows 1..8 one cycle delayed; core_channel high exactly 10 cycles; m_bits_valid at cycle 19 after first beat, equal to core_bits; FLUSH pulses core_rst for 1 cycle.
- cfg_iter=0 -> 10 decode cycles; cfg_iter=15 with MAX_ITER=8 -> 80 decode cycles.
- s_llr_valid dropped after beat 5 -> underrun=1, core_rst pulse, no m_bits_valid, frame_cnt=0; next full frame decodes normally and underrun stays 1.
- m_bits_ready held low after frame 1 -> s_llr_ready=0 in IDLE, m_bits stable; raise m_bits_ready -> frame_cnt=1, next frame accepted the same cycle.
- Assert rst mid-DECODE -> immediately core_channel=0, core_rst=1, busy=0, m_bits_valid=0.
- Deliver 65536 frames (or force the counter near wrap) -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/scan_frame_ctrl.sv
// Frame sequencer for the SCAN decoder core: loads N LLRs, runs the core for a
// clamped number of iterations, captures the decoded frame and flushes the core.
module scan_frame_ctrl #(
  parameter int unsigned N           = 1024,
  parameter int unsigned Q           = 6,
  parameter int unsigned ITER_CYCLES = 2048,
  parameter int unsigned MAX_ITER    = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_llr_valid,
  output logic         s_llr_ready,
  input  logic [Q-1:0] s_llr_data,
  input  logic [3:0]   cfg_iter,
  output logic         core_channel,
  output logic         core_rst,
  output logic [Q-1:0] core_llr,
  input  logic [N-1:0] core_bits,
  output logic         m_bits_valid,
  input  logic         m_bits_ready,
  output logic [N-1:0] m_bits,
  output logic         busy,
  output logic         underrun,
  output logic [15:0]  frame_cnt
);

  localparam int unsigned BEAT_W = $clog2(N + 1);
  localparam int unsigned CYC_W  = $clog2(ITER_CYCLES * MAX_ITER + 1);
  localparam logic [3:0]  MAX_ITER_L = 4'(MAX_ITER);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DECODE,
    S_CAPTURE,
    S_FLUSH
  } state_e;

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic [CYC_W-1:0]    last_q, last_d;
  logic [Q-1:0]        llr_q, llr_d;
  logic [N-1:0]        bits_q, bits_d;
  logic                bits_vld_q, bits_vld_d;
  logic                underrun_q, underrun_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic                chan_q, chan_d;
  logic                core_rst_q, core_rst_d;
  logic                busy_q, busy_d;

  logic                ready_c;
  logic                in_hs_c;
  logic                out_hs_c;
  logic [3:0]          iter_eff_c;

  // Upstream ready: IDLE only admits a new frame once the output register is free.
  always_comb begin
    ready_c = 1'b0;
    case (state_q)
      S_IDLE:  ready_c = !bits_vld_q || m_bits_ready;
      S_LOAD:  ready_c = 1'b1;
      default: ready_c = 1'b0;
    endcase
  end

  assign in_hs_c  = s_llr_valid && ready_c;
  assign out_hs_c = bits_vld_q && m_bits_ready;

  always_comb begin
    iter_eff_c = cfg_iter;
    if (cfg_iter == 4'd0) begin
      iter_eff_c = 4'd1;
    end else if (cfg_iter > MAX_ITER_L) begin
      iter_eff_c = MAX_ITER_L;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      cyc_q       <= '0;
      last_q      <= '0;
      llr_q       <= '0;
      bits_q      <= '0;
      bits_vld_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_cnt_q <= '0;
      chan_q      <= 1'b0;
      core_rst_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      cyc_q       <= cyc_d;
      last_q      <= last_d;
      llr_q       <= llr_d;
      bits_q      <= bits_d;
      bits_vld_q  <= bits_vld_d;
      underrun_q  <= underrun_d;
      frame_cnt_q <= frame_cnt_d;
      chan_q      <= chan_d;
      core_rst_q  <= core_rst_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    cyc_d       = cyc_q;
    last_d      = last_q;
    llr_d       = llr_q;
    bits_d      = bits_q;
    bits_vld_d  = bits_vld_q;
    underrun_d  = underrun_q;
    frame_cnt_d = frame_cnt_q;
    chan_d      = 1'b0;
    core_rst_d  = 1'b0;
    busy_d      = 1'b0;

    if (in_hs_c) begin
      llr_d = s_llr_data;
    end

    if (out_hs_c) begin
      bits_vld_d  = 1'b0;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (in_hs_c) begin
          last_d  = CYC_W'(ITER_CYCLES * 32'(iter_eff_c) - 32'd1);
          beat_d  = BEAT_W'(1);
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // A gap in the LLR stream corrupts the frame: drop it and flush the core.
        if (!s_llr_valid) begin
          underrun_d = 1'b1;
          state_d    = S_FLUSH;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == BEAT_W'(N - 1)) begin
            cyc_d   = '0;
            state_d = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        cyc_d = cyc_q + CYC_W'(1);
        if (cyc_q == last_q) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        // Capture wins over a same-cycle downstream handshake so the new frame stays valid.
        bits_d     = core_bits;
        bits_vld_d = 1'b1;
        state_d    = S_FLUSH;
      end
      S_FLUSH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    chan_d     = (state_d == S_DECODE);
    core_rst_d = (state_d == S_FLUSH);
    busy_d     = (state_d != S_IDLE);
  end

  assign s_llr_ready  = ready_c;
  assign core_channel = chan_q;
  assign core_rst     = core_rst_q;
  assign core_llr     = llr_q;
  assign m_bits_valid = bits_vld_q;
  assign m_bits       = bits_q;
  assign busy         = busy_q;
  assign underrun     = underrun_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_scan_frame_ctrl.sv
// Directed bench for scan_frame_ctrl with a small frame (N=8, 10 cycles/iteration).
module tb_scan_frame_ctrl;

  localparam int unsigned NB = 8;
  localparam int unsigned QB = 6;

  logic          clk;
  logic          rst;
  logic          s_llr_valid;
  logic          s_llr_ready;
  logic [QB-1:0] s_llr_data;
  logic [3:0]    cfg_iter;
  logic          core_channel;
  logic          core_rst;
  logic [QB-1:0] core_llr;
  logic [NB-1:0] core_bits;
  logic          m_bits_valid;
  logic          m_bits_ready;
  logic [NB-1:0] m_bits;
  logic          busy;
  logic          underrun;
  logic [15:0]   frame_cnt;

  int checks;
  int errors;
  logic [QB-1:0] llr_log [NB];

  scan_frame_ctrl #(
    .N(NB), .Q(QB), .ITER_CYCLES(10), .MAX_ITER(8)
  ) dut (
    .clk(clk), .rst(rst),
    .s_llr_valid(s_llr_valid), .s_llr_ready(s_llr_ready), .s_llr_data(s_llr_data),
    .cfg_iter(cfg_iter),
    .core_channel(core_channel), .core_rst(core_rst), .core_llr(core_llr),
    .core_bits(core_bits),
    .m_bits_valid(m_bits_valid), .m_bits_ready(m_bits_ready), .m_bits(m_bits),
    .busy(busy), .underrun(underrun), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Drives one frame from the current negedge; optionally drops valid from beat drop_at.
  task automatic do_frame(input logic [3:0] iter, input logic [QB-1:0] base, input int drop_at,
                          input int bound, output int lat, output int chan_hi, output int rst_hi,
                          output bit got);
    lat = 0; chan_hi = 0; rst_hi = 0; got = 1'b0;
    for (int k = 0; k < int'(NB); k++) begin
      if (drop_at >= 0 && k >= drop_at) begin
        s_llr_valid = 1'b0;
      end else begin
        s_llr_valid = 1'b1;
        s_llr_data  = base + QB'(k);
        cfg_iter    = iter;
      end
      @(negedge clk);
      lat++;
      chan_hi += int'(core_channel);
      rst_hi  += int'(core_rst);
      llr_log[k] = core_llr;
    end
    s_llr_valid = 1'b0;
    while (!m_bits_valid && lat < bound) begin
      @(negedge clk);
      lat++;
      chan_hi += int'(core_channel);
      rst_hi  += int'(core_rst);
    end
    got = m_bits_valid;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (core_channel !== 1'b0) begin errors++; $display("FAIL reset_channel got %0b exp 0", core_channel); end
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst got %0b exp 1", core_rst); end
    checks++; if (core_llr !== 6'd0) begin errors++; $display("FAIL reset_llr got %0d exp 0", core_llr); end
    checks++; if (m_bits !== 8'd0) begin errors++; $display("FAIL reset_m_bits got %0h exp 0", m_bits); end
    checks++; if (m_bits_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", m_bits_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %0b exp 0", underrun); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d exp 0", frame_cnt); end
    checks++; if (s_llr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", s_llr_ready); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (core_rst !== 1'b0) begin errors++; $display("FAIL post_reset_core_rst got %0b exp 0", core_rst); end
  endtask

  task automatic test_basic;
    int lat, chan_hi, rst_hi;
    bit got;
    core_bits = 8'hA5;
    do_frame(4'd1, 6'd1, -1, 150, lat, chan_hi, rst_hi, got);
    for (int k = 0; k < int'(NB); k++) begin
      checks++; if (llr_log[k] !== QB'(k + 1)) begin errors++; $display("FAIL basic_llr[%0d] got %0d exp %0d", k, llr_log[k], k + 1); end
    end
    checks++; if (lat !== 19) begin errors++; $display("FAIL basic_latency got %0d exp 19", lat); end
    checks++; if (chan_hi !== 10) begin errors++; $display("FAIL basic_channel_cycles got %0d exp 10", chan_hi); end
    checks++; if (rst_hi !== 1) begin errors++; $display("FAIL basic_flush_cycles got %0d exp 1", rst_hi); end
    checks++; if (m_bits !== 8'hA5) begin errors++; $display("FAIL basic_m_bits got %0h exp a5", m_bits); end
    @(negedge clk);
    checks++; if (core_rst !== 1'b0) begin errors++; $display("FAIL basic_flush_end got %0b exp 0", core_rst); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %0b exp 0", busy); end
    checks++; if (m_bits_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_clear got %0b exp 0", m_bits_valid); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL basic_frame_cnt got %0d exp 1", frame_cnt); end
  endtask

  task automatic test_iter_clamp;
    int lat, chan_hi, rst_hi;
    bit got;
    core_bits = 8'h5A;
    do_frame(4'd0, 6'd10, -1, 150, lat, chan_hi, rst_hi, got);
    checks++; if (chan_hi !== 10) begin errors++; $display("FAIL iter0_channel_cycles got %0d exp 10", chan_hi); end
    checks++; if (lat !== 19) begin errors++; $display("FAIL iter0_latency got %0d exp 19", lat); end
    checks++; if (m_bits !== 8'h5A) begin errors++; $display("FAIL iter0_m_bits got %0h exp 5a", m_bits); end
    @(negedge clk);
    core_bits = 8'hC3;
    do_frame(4'd15, 6'd20, -1, 150, lat, chan_hi, rst_hi, got);
    checks++; if (chan_hi !== 80) begin errors++; $display("FAIL iter15_channel_cycles got %0d exp 80", chan_hi); end
    checks++; if (lat !== 89) begin errors++; $display("FAIL iter15_latency got %0d exp 89", lat); end
    checks++; if (m_bits !== 8'hC3) begin errors++; $display("FAIL iter15_m_bits got %0h exp c3", m_bits); end
    @(negedge clk);
    checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL iter_frame_cnt got %0d exp 3", frame_cnt); end
  endtask

  task automatic test_underrun;
    int lat, chan_hi, rst_hi;
    bit got;
    core_bits = 8'h0F;
    do_frame(4'd1, 6'd30, 5, 40, lat, chan_hi, rst_hi, got);
    checks++; if (got !== 1'b0) begin errors++; $display("FAIL underrun_no_output got %0b exp 0", got); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_flag got %0b exp 1", underrun); end
    checks++; if (rst_hi !== 1) begin errors++; $display("FAIL underrun_flush got %0d exp 1", rst_hi); end
    checks++; if (chan_hi !== 0) begin errors++; $display("FAIL underrun_channel got %0d exp 0", chan_hi); end
    checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL underrun_frame_cnt got %0d exp 3", frame_cnt); end
    core_bits = 8'h96;
    do_frame(4'd1, 6'd40, -1, 150, lat, chan_hi, rst_hi, got);
    checks++; if (lat !== 19) begin errors++; $display("FAIL underrun_next_latency got %0d exp 19", lat); end
    checks++; if (m_bits !== 8'h96) begin errors++; $display("FAIL underrun_next_bits got %0h exp 96", m_bits); end
    @(negedge clk);
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky got %0b exp 1", underrun); end
    checks++; if (frame_cnt !== 16'd4) begin errors++; $display("FAIL underrun_next_cnt got %0d exp 4", frame_cnt); end
  endtask

  task automatic test_back_to_back;
    int lat, chan_hi, rst_hi;
    bit got;
    m_bits_ready = 1'b0;
    core_bits = 8'h3C;
    do_frame(4'd1, 6'd50, -1, 150, lat, chan_hi, rst_hi, got);
    checks++; if (lat !== 19) begin errors++; $display("FAIL hold_latency got %0d exp 19", lat); end
    core_bits = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (m_bits_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] got %0b exp 1", i, m_bits_valid); end
      checks++; if (m_bits !== 8'h3C) begin errors++; $display("FAIL hold_bits[%0d] got %0h exp 3c", i, m_bits); end
      checks++; if (s_llr_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d] got %0b exp 0", i, s_llr_ready); end
      checks++; if (frame_cnt !== 16'd4) begin errors++; $display("FAIL hold_cnt[%0d] got %0d exp 4", i, frame_cnt); end
    end
    m_bits_ready = 1'b1;
    #1;
    checks++; if (s_llr_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %0b exp 1", s_llr_ready); end
    core_bits = 8'h81;
    do_frame(4'd1, 6'd60, -1, 150, lat, chan_hi, rst_hi, got);
    checks++; if (llr_log[0] !== 6'd60) begin errors++; $display("FAIL b2b_first_llr got %0d exp 60", llr_log[0]); end
    checks++; if (lat !== 19) begin errors++; $display("FAIL b2b_latency got %0d exp 19", lat); end
    checks++; if (m_bits !== 8'h81) begin errors++; $display("FAIL b2b_bits got %0h exp 81", m_bits); end
    @(negedge clk);
    checks++; if (frame_cnt !== 16'd6) begin errors++; $display("FAIL b2b_cnt got %0d exp 6", frame_cnt); end
  endtask

  task automatic test_reset_mid_decode;
    for (int k = 0; k < int'(NB); k++) begin
      s_llr_valid = 1'b1;
      s_llr_data  = QB'(k);
      cfg_iter    = 4'd2;
      @(negedge clk);
    end
    s_llr_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (core_channel !== 1'b1) begin errors++; $display("FAIL mid_channel got %0b exp 1", core_channel); end
    rst = 1'b1;
    #1;
    checks++; if (core_channel !== 1'b0) begin errors++; $display("FAIL rst_mid_channel got %0b exp 0", core_channel); end
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL rst_mid_core_rst got %0b exp 1", core_rst); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %0b exp 0", busy); end
    checks++; if (m_bits_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %0b exp 0", m_bits_valid); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL rst_mid_underrun got %0b exp 0", underrun); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_cnt got %0d exp 0", frame_cnt); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wrap;
    int lat, chan_hi, rst_hi;
    bit got;
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    checks++; if (frame_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_preset got %0h exp ffff", frame_cnt); end
    core_bits = 8'h42;
    do_frame(4'd1, 6'd5, -1, 150, lat, chan_hi, rst_hi, got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL wrap_frame got %0b exp 1", got); end
    @(negedge clk);
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL wrap_cnt got %0h exp 0", frame_cnt); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk = 1'b0;
    rst = 1'b1;
    s_llr_valid = 1'b0;
    s_llr_data = '0;
    cfg_iter = 4'd1;
    core_bits = '0;
    m_bits_ready = 1'b1;
    test_reset();
    test_basic();
    test_iter_clamp();
    test_underrun();
    test_back_to_back();
    test_reset_mid_decode();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
